pla_vector_sweeper: RTL and testbench

- Sequential stimulus/response stage that wraps a combinational restricted-PLA function under test (NIN inputs, one output).
- Enumerates input vectors, optionally restricted to a cube given by a care mask and care value, and drives them to the function inputs.
- Samples the function output one cycle later and accumulates the onset count, the applied-vector count and a MISR signature.
- Used to compare restricted (autosymmetry-reduced) netlists against their originals.

---
 rtl/pla_sweep_pkg.sv | 23 ++
 rtl/pla_sweep_misr.sv | 43 ++++
 rtl/pla_vector_sweeper.sv | 173 +++++++++++++++++
 tb/tb_pla_vector_sweeper.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pla_sweep_pkg.sv
// pla_sweep_pkg
//   Shared types and constants for the PLA vector sweeper.
//   - sweep_state_e : sweeper FSM state encoding
//   - SIG_POLY_DEF  : default MISR feedback polynomial
//   - SIG_SEED_DEF  : default MISR initial value
//   - cnt_w_ok()    : true when a count width can hold 2^nin without wrapping
package pla_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sweep_state_e;

   localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
   localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;

   function automatic bit cnt_w_ok(input int nin, input int cnt_w);
      return (cnt_w >= nin + 1);
   endfunction

endpackage

// File: rtl/pla_sweep_misr.sv
// pla_sweep_misr
//   Single-input MISR compacting the sampled function-output stream.
//   Ports:
//     clk   : clock
//     rst   : synchronous active-high reset, loads SIG_SEED
//     clear : reload SIG_SEED (start of a new sweep)
//     en    : shift in d_in this edge
//     d_in  : serial data bit
//     sig   : current signature
module pla_sweep_misr #(
   parameter int              SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
   parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic             d_in,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = SIG_SEED;
      end else if (en) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
               ^ {{(SIG_W-1){1'b0}}, d_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) sig_q <= SIG_SEED;
      else     sig_q <= sig_d;
   end

   assign sig = sig_q;

endmodule

// File: rtl/pla_vector_sweeper.sv
// pla_vector_sweeper
//   Enumerates input vectors (optionally restricted to the cube given by
//   care_mask/care_value), drives them to a combinational function under test,
//   samples its output one cycle later and accumulates onset count, applied
//   count and a MISR signature.
//   Build option: define PLA_SWEEP_SIG_EN to build the MISR; otherwise
//   signature is tied to 0.
//   Ports:
//     clk, rst                : clock, synchronous active-high reset
//     start                   : begin a sweep (accepted in IDLE or DONE)
//     care_mask, care_value   : restriction cube, latched at start
//     x_out, x_valid          : vector to the function, valid for sampling
//     y_in                    : function output
//     busy, done              : sweep running / results valid
//     onset_count, applied_count, signature : results
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   SWEEP | issuing one candidate vector per cycle
//   DRAIN | sampling the last issued vector
//   DONE  | results frozen, waiting for start
module pla_vector_sweeper
   import pla_sweep_pkg::*;
#(
   parameter int               NIN      = 15,
   parameter int               CNT_W    = 16,
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEF,
   parameter logic [SIG_W-1:0] SIG_SEED = SIG_SEED_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NIN-1:0]   care_mask,
   input  logic [NIN-1:0]   care_value,
   output logic [NIN-1:0]   x_out,
   output logic             x_valid,
   input  logic             y_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] onset_count,
   output logic [CNT_W-1:0] applied_count,
   output logic [SIG_W-1:0] signature
);

   if (!cnt_w_ok(NIN, CNT_W)) begin : g_bad_cnt_w
      $error("pla_vector_sweeper: CNT_W must be at least NIN+1");
   end

   sweep_state_e     state_q, state_d;
   logic [NIN-1:0]   cnt_q, cnt_d;
   logic [NIN-1:0]   mask_q, mask_d;
   logic [NIN-1:0]   value_q, value_d;
   logic [NIN-1:0]   x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] onset_q, onset_d;
   logic [CNT_W-1:0] applied_q, applied_d;

   logic accept;
   logic sample;
   logic match;

   assign accept = start && ((state_q == IDLE) || (state_q == DONE));
   // A vector issued last edge is sampled on this edge, in SWEEP or DRAIN.
   assign sample = x_valid_q && ((state_q == SWEEP) || (state_q == DRAIN));
   assign match  = (((cnt_q ^ value_q) & mask_q) == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      value_d   = value_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      busy_d    = busy_q;
      done_d    = done_q;
      onset_d   = onset_q;
      applied_d = applied_q;

      if (sample) begin
         applied_d = applied_q + 1'b1;
         onset_d   = onset_q + {{(CNT_W-1){1'b0}}, y_in};
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mask_d    = care_mask;
               value_d   = care_value;
               cnt_d     = '0;
               onset_d   = '0;
               applied_d = '0;
               done_d    = 1'b0;
               busy_d    = 1'b1;
               state_d   = SWEEP;
            end
         end
         SWEEP: begin
            if (match) begin
               x_d       = cnt_q;
               x_valid_d = 1'b1;
            end else begin
               x_valid_d = 1'b0;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = DRAIN;
         end
         DRAIN: begin
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mask_q    <= '0;
         value_q   <= '0;
         x_q       <= '0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         onset_q   <= '0;
         applied_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         value_q   <= value_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         onset_q   <= onset_d;
         applied_q <= applied_d;
      end
   end

`ifdef PLA_SWEEP_SIG_EN
   pla_sweep_misr #(
      .SIG_W   (SIG_W),
      .SIG_POLY(SIG_POLY),
      .SIG_SEED(SIG_SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .clear(accept),
      .en   (sample),
      .d_in (y_in),
      .sig  (signature)
   );
`else
   // Signature compaction not built; keep the parameters referenced.
   logic unused_sig_cfg;
   assign unused_sig_cfg = ^{SIG_POLY, SIG_SEED, accept};
   assign signature      = '0;
`endif

   assign x_out         = x_q;
   assign x_valid       = x_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign onset_count   = onset_q;
   assign applied_count = applied_q;

endmodule

// File: tb/tb_pla_vector_sweeper.sv
module tb_pla_vector_sweeper;

   localparam int NIN = 4;
   localparam int NV  = 1 << NIN;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [NIN-1:0]  care_mask;
   logic [NIN-1:0]  care_value;
   logic [NIN-1:0]  x_out;
   logic            x_valid;
   logic            y_in;
   logic            busy;
   logic            done;
   logic [15:0]     onset_count;
   logic [15:0]     applied_count;
   logic [15:0]     signature;

   logic [NV-1:0]   tt;   // truth table of the function under test

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   assign y_in = tt[x_out];

   pla_vector_sweeper #(
      .NIN  (NIN),
      .CNT_W(16),
      .SIG_W(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .care_mask    (care_mask),
      .care_value   (care_value),
      .x_out        (x_out),
      .x_valid      (x_valid),
      .y_in         (y_in),
      .busy         (busy),
      .done         (done),
      .onset_count  (onset_count),
      .applied_count(applied_count),
      .signature    (signature)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sig_reset();
`ifdef PLA_SWEEP_SIG_EN
      return 16'hFFFF;
`else
      return 16'h0000;
`endif
   endfunction

   // Full sweep with reference model. pulse_at > 0 re-pulses start on that
   // cycle after acceptance (must be ignored).
   task automatic run_sweep(input string tag, input logic [NIN-1:0] cm,
                            input logic [NIN-1:0] cv, input logic [NV-1:0] f,
                            input int pulse_at);
      logic [NIN-1:0] exp_q[$];
      logic [NIN-1:0] got_q[$];
      int             exp_applied, exp_onset, done_cyc;
      logic [15:0]    msig, exp_sig;

      exp_applied = 0;
      exp_onset   = 0;
      msig        = 16'hFFFF;
      for (int v = 0; v < NV; v++) begin
         if (((v ^ int'(cv)) & int'(cm)) == 0) begin
            exp_q.push_back(NIN'(v));
            exp_applied++;
            exp_onset += int'(f[v]);
            msig = {msig[14:0], 1'b0} ^ (msig[15] ? 16'h1021 : 16'h0) ^ {15'b0, f[v]};
         end
      end
`ifdef PLA_SWEEP_SIG_EN
      exp_sig = msig;
`else
      exp_sig = 16'h0000;
`endif

      @(negedge clk);
      care_mask  = cm;
      care_value = cv;
      tt         = f;
      start      = 1'b1;
      @(posedge clk);  // edge E
      #1;
      start      = 1'b0;
      care_mask  = NIN'($urandom);   // latched copy must be used
      care_value = NIN'($urandom);
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      check({tag, " done_cleared"}, 32'(done), 32'd0);
      check({tag, " applied_cleared"}, 32'(applied_count), 32'd0);

      done_cyc = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (x_valid) got_q.push_back(x_out);
         start = (cyc == pulse_at);
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      start = 1'b0;

      check({tag, " done_cycle"}, 32'(done_cyc), 32'(NV + 1));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      check({tag, " applied"}, 32'(applied_count), 32'(exp_applied));
      check({tag, " onset"}, 32'(onset_count), 32'(exp_onset));
      check({tag, " signature"}, 32'(signature), 32'(exp_sig));
      check({tag, " n_issued"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, " issued_vec"}, 32'(got_q[i]), 32'(exp_q[i]));

      repeat (3) @(posedge clk);
      #1;
      check({tag, " done_held"}, 32'(done), 32'd1);
      check({tag, " applied_frozen"}, 32'(applied_count), 32'(exp_applied));
      check({tag, " sig_frozen"}, 32'(signature), 32'(exp_sig));
      check({tag, " x_valid_idle"}, 32'(x_valid), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      care_mask  = '0;
      care_value = '0;
      tt         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst x_out", 32'(x_out), 32'd0);
      check("rst x_valid", 32'(x_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst onset", 32'(onset_count), 32'd0);
      check("rst applied", 32'(applied_count), 32'd0);
      check("rst signature", 32'(signature), 32'(sig_reset()));
      rst = 1'b0;

      run_sweep("full_and", 4'b0000, 4'b0000, 16'h8000, 0);
      run_sweep("cube_x0", 4'b0011, 4'b0001, 16'hAAAA, 0);
      run_sweep("point", 4'b1111, 4'b1010, NV'($urandom), 0);

      // Reset six cycles into a sweep.
      @(negedge clk);
      care_mask = '0;
      tt        = 16'hFFFF;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst onset", 32'(onset_count), 32'd0);
      check("midrst applied", 32'(applied_count), 32'd0);
      check("midrst signature", 32'(signature), 32'(sig_reset()));
      check("midrst x_valid", 32'(x_valid), 32'd0);
      check("midrst x_out", 32'(x_out), 32'd0);
      rst = 1'b0;

      run_sweep("after_rst", 4'b0000, 4'b0000, NV'($urandom), 0);
      run_sweep("restart_busy", 4'b0100, 4'b0100, NV'($urandom), 5);

      for (int k = 0; k < 6; k++)
         run_sweep("random", NIN'($urandom), NIN'($urandom), NV'($urandom), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
